uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart` byte transmitter between `NUM_REQ` requesters. It accepts one byte at a time over per-requester valid/ready handshakes and drives the transmitter's `send`/`data` inputs. It tracks the transmitter's `done` output through each frame and drops a byte with an error pulse if the transmitter never starts. It sits between software-facing producers (register block, debug streamer, …) and the single `uart` instance on the TX pin.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16: clock cycles allowed in SEND for `uart_done` to fall, ≥ 4.

Ports:
- `clock` in 1: single clock domain.
- `reset_n` in 1: reset is asynchronous and active-low.
- `req_valid` in `NUM_REQ`: requester i has a byte on its `req_data` slice.
- `req_data` in `8*NUM_REQ`: byte of requester i is bits [8i+7:8i].
- `req_ready` out `NUM_REQ`: one-hot or zero; a byte transfers when `req_valid[i] && req_ready[i]`.
- `uart_send` out 1: to `uart.send`.
- `uart_data` out 8: to `uart.data`.
- `uart_done` in 1: from `uart.done`; high means the transmitter is idle.
- `grant_id` out `$clog2(NUM_REQ)`: index of the requester owning the current frame.
- `busy` out 1: high in SEND or WAIT.
- `timeout_err` out 1: one-cycle pulse when a byte is dropped.

## Operation
State machine with three states.

IDLE:
- `req_ready` is combinational. Bit w is high only when `uart_done` = 1, at least one `req_valid` is high, and w is the winner.
- The winner is the first set `req_valid` bit searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
- On transfer:
  - `uart_data` <= the winner's byte.
  - `grant_id` <= w.
  - Clear the watchdog.
  - Go to SEND.
- If `uart_done` = 0, no grant is issued.

SEND:
- `uart_send` = 1; `uart_data` is held constant.
- `uart_done` = 0 → `uart_send` <= 0, go to WAIT.
- Otherwise, when the watchdog reaches `TIMEOUT-1`:
  - `uart_send` <= 0, pulse `timeout_err`.
  - `last_grant` <= `grant_id`, go to IDLE.
  - The byte is dropped.

WAIT:
- `uart_send` = 0; `uart_data` is held.
- `uart_done` = 1 → `last_grant` <= `grant_id`, go to IDLE.

Other rules:
- `last_grant` updates only at the end of a frame (success or timeout), so priority rotates per byte.
- A requester that drops `req_valid` before transfer loses nothing and is simply skipped.
- `req_data` is sampled only in the transfer cycle.
- Reset values: state IDLE, `uart_send` 0, `uart_data` 8'h00, `grant_id` 0, `busy` 0, `timeout_err` 0, `req_ready` 0, watchdog 0, `last_grant` `NUM_REQ-1` (requester 0 wins first).
- Reset asserted mid-frame: all registers take their reset values immediately. An accepted byte is lost and no error pulse is emitted.

## Timing
- Transfer at edge T → `uart_send` = 1 and `busy` = 1 from T+1.
- `uart_send` deasserts on the edge after `uart_done` is first sampled low.
- Frame end: the edge that samples `uart_done` = 1 in WAIT moves to IDLE. A new `req_ready` can assert in that same following cycle, so there are no idle cycles between back-to-back bytes beyond the transmitter's own.
- Watchdog is a `$clog2(TIMEOUT)`-bit counter, incremented every SEND cycle. The timeout fires on the edge after `TIMEOUT` SEND cycles.
- `timeout_err` is high for exactly the first IDLE cycle after a timeout.
- Simultaneous `uart_done` fall and watchdog limit in SEND: `uart_done` wins; no error.
- `busy` is registered and equals (state ≠ IDLE).

## Structure
- Package `uart_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_SEND, ARB_WAIT}.
  - `UART_DATA_W` = 8.
  - Default `TIMEOUT` constant.
- Sub-module `rr_pick`: purely combinational. Inputs `req` vector and `last` index; outputs one-hot `gnt` and index `gnt_id`. Parameterised by `NUM_REQ`.
- The top level holds the FSM, data/grant registers and watchdog.

## Test plan
- Reset then single request: `req_valid` = 4'b0100, byte 8'hA5, model `uart` attached. Required: `req_ready[2]` pulses once; `uart_send` high from the next cycle; the TX line shows start bit, 1,0,1,0,0,1,0,1, stop bit; `grant_id` = 2.
- Contention: all four valid with bytes 8'h10..8'h13, held. Required: bytes are sent in order 10,11,12,13,10…; each `req_ready` is one cycle per byte.
- Rotation fairness: req0 and req3 valid continuously. Required: grants alternate 0,3,0,3.
- Timeout: `uart_done` forced high and never falls. Required: `uart_send` is high for exactly `TIMEOUT` cycles; `timeout_err` pulses once; the next grant goes to the next requester.
- Reset mid-frame: `reset_n` low during WAIT. Required: `uart_send`, `busy`, `timeout_err` and `req_ready` are 0 asynchronously; after release, requester 0 has priority.
- `uart_done` low while idle with `req_valid` set. Required: `req_ready` stays 0 until `uart_done` rises.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SEND,
        ARB_WAIT
    } arb_state_t;

    localparam int UART_DATA_W     = 8;
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;
    logic           found;

    // Search upward from last+1; the final step (k = NUM_REQ) revisits last itself.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART byte transmitter with a start watchdog
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           uart_send,
    output logic [UART_DATA_W-1:0]         uart_data,
    input  logic                           uart_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT);

    arb_state_t             state_q;
    logic                   send_q;
    logic [UART_DATA_W-1:0] data_q;
    logic [IDW-1:0]         gid_q;
    logic                   busy_q;
    logic                   terr_q;
    logic [WDW-1:0]         wd_q;
    logic [IDW-1:0]         last_q;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDW-1:0]         pick_id;
    logic [UART_DATA_W-1:0] pick_byte;
    logic                   can_grant;
    logic                   xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .last   (last_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                pick_byte = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
    end

    // reset_n gates ready so no handshake is offered while reset is held.
    assign can_grant = reset_n && (state_q == ARB_IDLE) && uart_done;
    assign req_ready = can_grant ? pick_gnt : '0;
    assign xfer      = |req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            send_q  <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            wd_q    <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (xfer) begin
                        state_q <= ARB_SEND;
                        send_q  <= 1'b1;
                        data_q  <= pick_byte;
                        gid_q   <= pick_id;
                        wd_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_SEND: begin
                    // A falling done takes precedence over a watchdog expiring on the same edge.
                    if (!uart_done) begin
                        send_q  <= 1'b0;
                        state_q <= ARB_WAIT;
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        send_q  <= 1'b0;
                        terr_q  <= 1'b1;
                        last_q  <= gid_q;
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                ARB_WAIT: begin
                    if (uart_done) begin
                        last_q  <= gid_q;
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    send_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_send   = send_q;
    assign uart_data   = data_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        uart_send;
    logic [7:0]  uart_data;
    logic        uart_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .uart_send   (uart_send),
        .uart_data   (uart_data),
        .uart_done   (uart_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Transmitter model: mode 0 = normal frames, 1 = never starts, 2 = stuck busy.
    int   mode = 0;
    logic done_m = 1'b1;
    int   cnt = 0;

    always @(posedge clock) begin
        if (done_m && uart_send && mode == 0) begin
            done_m <= 1'b0;
            cnt    <= $urandom_range(1, 6);
        end else if (!done_m) begin
            if (cnt == 0) done_m <= 1'b1;
            else          cnt    <= cnt - 1;
        end
    end

    assign uart_done = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : done_m;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic wait_xfer(output int id, output logic [7:0] byt, output bit ok);
        id = -1; byt = '0; ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) id = i;
                byt = req_data[8*id +: 8];
                ok  = 1'b1;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic post_check(input int id, input logic [7:0] byt);
        @(negedge clock);
        check("post_send", uart_send, 1);
        check("post_busy", busy, 1);
        check("post_data", uart_data, byt);
        check("post_gid", grant_id, id);
        check("post_ready", req_ready, 0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clock);
            if (!busy && uart_done) ok = 1'b1;
        end
        check("idle_reached", ok, 1);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl[11];
    int   id, send_cnt, err_cnt, model_last, exp_w, streak, max_streak, xfers, pend_id;
    logic [7:0] byt, pend_byte;
    logic [3:0] exp_oh;
    bit   ok, pending, legal;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        tbl[1]  = '{4'b1111, 32'h1312_1110, 3, 8'h13};
        tbl[2]  = '{4'b1111, 32'h1312_1110, 0, 8'h10};
        tbl[3]  = '{4'b1111, 32'h1312_1110, 1, 8'h11};
        tbl[4]  = '{4'b1111, 32'h1312_1110, 2, 8'h12};
        tbl[5]  = '{4'b1111, 32'h1312_1110, 3, 8'h13};
        tbl[6]  = '{4'b1111, 32'h1312_1110, 0, 8'h10};
        tbl[7]  = '{4'b1001, 32'h1312_1110, 3, 8'h13};
        tbl[8]  = '{4'b1001, 32'h1312_1110, 0, 8'h10};
        tbl[9]  = '{4'b1001, 32'h1312_1110, 3, 8'h13};
        tbl[10] = '{4'b1001, 32'h1312_1110, 0, 8'h10};

        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        repeat (3) @(negedge clock);
        check("rst_send", uart_send, 0);
        check("rst_data", uart_data, 0);
        check("rst_gid", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_ready", req_ready, 0);
        req_valid = 4'b0000;
        reset_n   = 1'b1;
        @(negedge clock);

        foreach (tbl[i]) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            wait_xfer(id, byt, ok);
            check("tbl_xfer", ok, 1);
            check("tbl_id", id, tbl[i].exp_id);
            check("tbl_byte", byt, tbl[i].exp_byte);
            post_check(tbl[i].exp_id, tbl[i].exp_byte);
        end
        req_valid = 4'b0000;
        wait_idle();

        mode      = 2;
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("done_low_ready", req_ready, 0);
        end
        mode = 0;
        #1;
        check("done_rise_ready", req_ready, 4'b0001);
        post_check(0, 8'h10);
        req_valid = 4'b0000;
        wait_idle();

        mode      = 1;
        req_valid = 4'b0011;
        wait_xfer(id, byt, ok);
        check("to_xfer", ok, 1);
        check("to_id", id, 1);
        send_cnt = 0;
        err_cnt  = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (uart_send) send_cnt++;
            if (timeout_err) begin
                err_cnt++;
                if (err_cnt == 1) begin
                    check("to_next_ready", req_ready, 4'b0001);
                    check("to_busy", busy, 0);
                    req_valid = 4'b0000;
                    mode      = 0;
                end
            end
        end
        check("to_send_cycles", send_cnt, TIMEOUT);
        check("to_err_pulses", err_cnt, 1);

        req_valid = 4'b0100;
        req_data  = 32'h4433_2211;
        wait_xfer(id, byt, ok);
        check("mr_id", id, 2);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clock);
            if (busy && !uart_send) ok = 1'b1;
        end
        check("mr_wait_reached", ok, 1);
        #2;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("mr_send", uart_send, 0);
        check("mr_busy", busy, 0);
        check("mr_terr", timeout_err, 0);
        check("mr_ready", req_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_xfer(id, byt, ok);
        check("mr_xfer", ok, 1);
        check("mr_first_id", id, 0);
        post_check(0, 8'h11);

        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n    = 1'b1;
        model_last = NUM_REQ - 1;
        pending    = 1'b0;
        streak     = 0;
        max_streak = 0;
        xfers      = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) req_valid = 4'($urandom);
            req_data = $urandom;
            #1;
            if (pending) begin
                check("rnd_send", uart_send, 1);
                check("rnd_data", uart_data, pend_byte);
                check("rnd_gid", grant_id, pend_id);
                pending = 1'b0;
            end
            exp_w  = winner(req_valid, model_last);
            exp_oh = (exp_w >= 0) ? 4'(1 << exp_w) : 4'b0000;
            legal  = (req_ready == 4'b0000) || (req_ready == exp_oh && uart_done);
            check("rnd_ready_legal", legal, 1);
            if (|(req_valid & req_ready)) begin
                pending    = 1'b1;
                pend_id    = exp_w;
                pend_byte  = req_data[8*exp_w +: 8];
                model_last = exp_w;
                streak     = 0;
                xfers++;
            end else if (|req_valid) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
            @(negedge clock);
        end
        check("rnd_no_starve", max_streak <= 40, 1);
        check("rnd_enough_xfers", xfers > 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
